// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and parameter limits.
package truth_table_sweeper_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      APPLY = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int unsigned N_IN_MIN   = 1;
   localparam int unsigned N_IN_MAX   = 8;
   localparam int unsigned N_OUT_MIN  = 1;
   localparam int unsigned N_OUT_MAX  = 8;
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;
   localparam int unsigned SETTLE_W   = 4;

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// Settle wait counter: loadable down-counter that stops at zero.
module settle_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Flag reflects the post-decrement count so the waiting state exits in the
   // same cycle the count reaches zero.
   assign zero_o = (cnt_d == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input pattern, compares DUT vs reference.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter int unsigned N_OUT  = 1,
   parameter int unsigned SETTLE = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   output logic [N_IN-1:0]  o_pattern,
   input  logic [N_OUT-1:0] i_dut_out,
   input  logic [N_OUT-1:0] i_expected,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [N_IN:0]    o_mismatch_cnt,
   output logic             o_fail_valid,
   output logic [N_IN-1:0]  o_fail_pattern
);

   localparam logic [N_IN-1:0]     LAST_PAT    = '1;
   localparam logic [N_IN-1:0]     PAT_ONE     = N_IN'(1);
   localparam logic [N_IN:0]       CNT_ONE     = (N_IN+1)'(1);
   localparam logic [N_IN:0]       CNT_MAX     = (N_IN+1)'(1) << N_IN;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

   state_t          state_q, state_d;
   logic [N_IN-1:0] pattern_q, pattern_d;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic            fail_valid_q, fail_valid_d;
   logic [N_IN-1:0] fail_pattern_q, fail_pattern_d;
   logic            pass_q, pass_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tmr_load, tmr_dec, tmr_zero;

   settle_timer #(.W(SETTLE_W)) u_settle_timer (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .load_i     (tmr_load),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d        = state_q;
      pattern_d      = pattern_q;
      cnt_d          = cnt_q;
      fail_valid_d   = fail_valid_q;
      fail_pattern_d = fail_pattern_q;
      pass_d         = pass_q;
      tmr_load       = 1'b0;
      tmr_dec        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               cnt_d        = '0;
               fail_valid_d = 1'b0;
               pass_d       = 1'b0;
               pattern_d    = '0;
               state_d      = APPLY;
            end
         end
         APPLY: begin
            tmr_load = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (i_dut_out != i_expected) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (!fail_valid_q) begin
                  fail_valid_d   = 1'b1;
                  fail_pattern_d = pattern_q;
               end
            end
            if (pattern_q == LAST_PAT) begin
               // o_pass is registered, so it is decided on entry to DONE to line up with o_done.
               pass_d  = (cnt_d == '0);
               state_d = DONE;
            end else begin
               pattern_d = pattern_q + PAT_ONE;
               state_d   = APPLY;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (i_abort && (state_q inside {APPLY, WAIT, CHECK})) begin
         state_d        = IDLE;
         pattern_d      = pattern_q;
         cnt_d          = cnt_q;
         fail_valid_d   = fail_valid_q;
         fail_pattern_d = fail_pattern_q;
         pass_d         = 1'b0;
         tmr_load       = 1'b0;
         tmr_dec        = 1'b0;
      end

      busy_d = (state_d inside {APPLY, WAIT, CHECK});
      done_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= IDLE;
         pattern_q      <= '0;
         cnt_q          <= '0;
         fail_valid_q   <= 1'b0;
         fail_pattern_q <= '0;
         pass_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pattern_q      <= pattern_d;
         cnt_q          <= cnt_d;
         fail_valid_q   <= fail_valid_d;
         fail_pattern_q <= fail_pattern_d;
         pass_q         <= pass_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign o_pattern      = pattern_q;
   assign o_mismatch_cnt = cnt_q;
   assign o_fail_valid   = fail_valid_q;
   assign o_fail_pattern = fail_pattern_q;
   assign o_pass         = pass_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;

endmodule
